// File: rtl/alu_div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring division on the shared ALU.
// Optional DIV_SEQ_EARLY_OUT_EN: unsigned A<B finishes at accept.
module alu_div_sequencer #(
    parameter logic [3:0] ALU_ADD_CODE = 4'b0000,
    parameter logic [3:0] ALU_SUB_CODE = 4'b0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        alu_req,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    input  logic        result_ready
);

    typedef enum logic [2:0] {
        IDLE, NEG_A, NEG_B, ITER, FIX, DONE
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  op_q, op_nx;
    logic [31:0] q_q, q_nx;
    logic [31:0] r_q, r_nx;
    logic [31:0] b_q, b_nx;
    logic [31:0] res_q, res_nx;
    logic [4:0]  cnt_q, cnt_nx;
    logic        sa_q, sa_nx;
    logic        sb_q, sb_nx;

    logic [31:0] l_val;
    logic [31:0] fix_val;
    logic        borrow;
    logic        ge;
    logic        fix_neg;
    logic        ovf;
    logic        early;

    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result       = res_q;
    assign alu_req      = (state == NEG_A) || (state == NEG_B) ||
                          (state == ITER)  || (state == FIX);

    always_comb begin
        state_nx    = state;
        op_nx       = op_q;
        q_nx        = q_q;
        r_nx        = r_q;
        b_nx        = b_q;
        res_nx      = res_q;
        cnt_nx      = cnt_q;
        sa_nx       = sa_q;
        sb_nx       = sb_q;
        alu_op1     = 32'd0;
        alu_op2     = 32'd0;
        alu_control = ALU_ADD_CODE;

        // Shift-in window {R, Q[31]} truncated to 32 bits; R[31] covers bit 32.
        l_val   = {r_q[30:0], q_q[31]};
        borrow  = (~l_val[31] & b_q[31]) |
                  (~(l_val[31] ^ b_q[31]) & alu_result[31]);
        ge      = r_q[31] | ~borrow;
        fix_val = op_q[1] ? r_q : q_q;
        fix_neg = op_q[1] ? sa_q : (sa_q ^ sb_q);
        ovf     = ~op[0] && (dividend == 32'h8000_0000) &&
                  (divisor == 32'hFFFF_FFFF);
`ifdef DIV_SEQ_EARLY_OUT_EN
        early   = op[0] && (dividend < divisor);
`else
        early   = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (start_valid && !flush) begin
                    op_nx  = op;
                    q_nx   = dividend;
                    b_nx   = divisor;
                    r_nx   = 32'd0;
                    cnt_nx = 5'd0;
                    sa_nx  = ~op[0] & dividend[31];
                    sb_nx  = ~op[0] & divisor[31];
                    if (divisor == 32'd0) begin
                        res_nx   = op[1] ? dividend : 32'hFFFF_FFFF;
                        state_nx = DONE;
                    end else if (ovf) begin
                        res_nx   = op[1] ? 32'd0 : 32'h8000_0000;
                        state_nx = DONE;
                    end else if (early) begin
                        res_nx   = op[1] ? dividend : 32'd0;
                        state_nx = DONE;
                    end else if (!op[0]) begin
                        state_nx = NEG_A;
                    end else begin
                        state_nx = ITER;
                    end
                end
            end
            NEG_A: begin
                alu_control = ALU_SUB_CODE;
                alu_op2     = q_q;
                if (sa_q) q_nx = alu_result;
                state_nx    = NEG_B;
            end
            NEG_B: begin
                alu_control = ALU_SUB_CODE;
                alu_op2     = b_q;
                if (sb_q) b_nx = alu_result;
                state_nx    = ITER;
            end
            ITER: begin
                alu_control = ALU_SUB_CODE;
                alu_op1     = l_val;
                alu_op2     = b_q;
                r_nx        = ge ? alu_result : l_val;
                q_nx        = {q_q[30:0], ge};
                cnt_nx      = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    if (!op_q[0]) begin
                        state_nx = FIX;
                    end else begin
                        res_nx   = op_q[1] ? (ge ? alu_result : l_val)
                                           : {q_q[30:0], ge};
                        state_nx = DONE;
                    end
                end
            end
            FIX: begin
                if (fix_neg) begin
                    alu_control = ALU_SUB_CODE;
                    alu_op2     = fix_val;
                end
                res_nx   = fix_neg ? alu_result : fix_val;
                state_nx = DONE;
            end
            DONE: begin
                if (result_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= 2'd0;
            q_q   <= 32'd0;
            r_q   <= 32'd0;
            b_q   <= 32'd0;
            res_q <= 32'd0;
            cnt_q <= 5'd0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
        end else begin
            state <= state_nx;
            op_q  <= op_nx;
            q_q   <= q_nx;
            r_q   <= r_nx;
            b_q   <= b_nx;
            res_q <= res_nx;
            cnt_q <= cnt_nx;
            sa_q  <= sa_nx;
            sb_q  <= sb_nx;
        end
    end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer with a behavioural ALU and result scoreboard.
// Latency is counted in clock edges after the accept edge.
module tb_alu_div_sequencer;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        alu_req;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic        result_ready;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    assign alu_result = (alu_control == SUB) ? alu_op1 - alu_op2
                                             : alu_op1 + alu_op2;

    alu_div_sequencer #(.ALU_ADD_CODE(ADD), .ALU_SUB_CODE(SUB)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
        .alu_req(alu_req), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_control(alu_control), .alu_result(alu_result),
        .busy(busy), .result_valid(result_valid), .result(result),
        .result_ready(result_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return o[1] ? 32'd0 : 32'h8000_0000;
            return o[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        end
        return o[1] ? a % b : a / b;
    endfunction

    function automatic int ref_lat(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef DIV_SEQ_EARLY_OUT_EN
        if (o[0] && a < b) return 0;
`endif
        return o[0] ? 32 : 35;
    endfunction

    task automatic reset_check(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_sready"}, 32'(start_ready), 32'd1);
        chk({tag, "_req"}, 32'(alu_req), 32'd0);
        chk({tag, "_op1"}, alu_op1, 32'd0);
        chk({tag, "_op2"}, alu_op2, 32'd0);
        chk({tag, "_ctl"}, 32'(alu_control), 32'(ADD));
        chk({tag, "_result"}, result, 32'd0);
    endtask

    // Called at a negedge; returns just after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start_valid = 1'b1;
        op          = o;
        dividend    = a;
        divisor     = b;
        exp_q.push_back(ref_res(o, a, b));
        lat_q.push_back(ref_lat(o, a, b));
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [1:0] o,
                               input int hold);
        int lat = 0;
        int req = 0;
        int sub = 0;
        int elat;
        logic [31:0] eres;
        logic [31:0] held;
        @(negedge clk);
        while (!result_valid && lat < 200) begin
            if (alu_req) req++;
            if (alu_req && alu_control == SUB) sub++;
            lat++;
            @(negedge clk);
        end
        chk({tag, "_timeout"}, 32'(result_valid), 32'd1);
        elat = lat_q.pop_front();
        eres = exp_q.pop_front();
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_reqcyc"}, 32'(req), 32'(elat));
        if (o[0]) chk({tag, "_subcyc"}, 32'(sub), 32'(elat));
        held = result;
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_res"}, result, held);
            chk({tag, "_hold_sready"}, 32'(start_ready), 32'd0);
            chk({tag, "_hold_valid"}, 32'(result_valid), 32'd1);
            @(negedge clk);
        end
        chk({tag, "_result"}, result, eres);
        chk({tag, "_done_req"}, 32'(alu_req), 32'd0);
        chk({tag, "_done_sready"}, 32'(start_ready), 32'd0);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({tag, "_post_sready"}, 32'(start_ready), 32'd1);
        chk({tag, "_post_valid"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        op           = 2'b00;
        dividend     = 32'd0;
        divisor      = 32'd0;
        flush        = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_check("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b01, 32'd100, 32'd7);
        wait_result("divu_100_7", 2'b01, 10);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_result("rem_m7_2", 2'b10, 0);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_m7_2", 2'b00, 0);
        issue(2'b00, 32'd7, 32'hFFFF_FFFE);
        wait_result("div_7_m2", 2'b00, 0);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_result("rem_7_m2", 2'b10, 0);
        issue(2'b00, 32'd5, 32'd0);
        wait_result("div_by0", 2'b00, 0);
        issue(2'b11, 32'd5, 32'd0);
        wait_result("remu_by0", 2'b11, 0);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 2'b00, 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("rem_ovf", 2'b10, 0);
        issue(2'b01, 32'd3, 32'd9);
        wait_result("divu_3_9", 2'b01, 0);
        issue(2'b11, 32'd3, 32'd9);
        wait_result("remu_3_9", 2'b11, 0);
        issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_result("divu_big", 2'b01, 0);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_result("div_min_min", 2'b00, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 30);
            issue(ro, ra, rb);
            wait_result("rand", ro, 0);
        end

        start_valid = 1'b1;
        op          = 2'b01;
        dividend    = 32'd1000;
        divisor     = 32'd3;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush       = 1'b1;
        start_valid = 1'b1;
        dividend    = 32'd50;
        divisor     = 32'd5;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(result_valid), 32'd0);
        chk("flush_sready", 32'(start_ready), 32'd1);
        flush = 1'b0;
        exp_q.push_back(32'd10);
        lat_q.push_back(32);
        @(posedge clk);
        #1 start_valid = 1'b0;
        chk("flush_reaccept", 32'(busy), 32'd1);
        wait_result("after_flush", 2'b01, 0);

        issue(2'b01, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        chk("mid_iter_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        reset_check("mid_reset");
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        @(negedge clk);
        issue(2'b11, 32'd1234567, 32'd1000);
        wait_result("remu_after_rst", 2'b11, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
